imem_loader: RTL

- Writer side of the instruction memory that the fetch stage reads.
- Receives a byte stream from the host/debug port through a valid/ready handshake.
- Assembles the bytes into XLEN-bit words and issues write cycles into instruction memory, starting at address 0.
- Holds the core (coreHold) until a complete, checksum-verified image is in memory.

---
 rtl/imem_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: frames N little-endian words plus an
// XOR checksum, writes them from address 0 and releases coreHold once the image verifies.
module imem_loader #(
    parameter int XLEN  = 32,
    parameter int PCLEN = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       byteIn,
    input  logic             byteValid,
    output logic             byteReady,
    output logic             wrEn,
    output logic [PCLEN-1:0] wrAddr,
    output logic [XLEN-1:0]  wrData,
    output logic             coreHold,
    output logic             done,
    output logic             error
);

    localparam int          BPW = XLEN / 8;
    localparam int          IW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned CAP = 32'd1 << PCLEN;

    typedef enum logic [2:0] {
        IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t            r_state;
    logic [15:0]       r_len;
    logic [15:0]       r_cnt;
    logic [IW-1:0]     r_idx;
    logic [7:0]        r_chk;
    logic [XLEN-1:0]   r_buf;

    logic              w_acc;
    logic [15:0]       w_len;
    logic [XLEN-1:0]   w_word;

    assign w_acc = byteValid && byteReady;
    assign w_len = {byteIn, r_len[7:0]};

    // Word buffer with the incoming byte already placed in its lane.
    always_comb begin
        w_word = r_buf;
        w_word[int'(r_idx)*8 +: 8] = byteIn;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_chk     <= '0;
            r_buf     <= '0;
            byteReady <= 1'b0;
            wrEn      <= 1'b0;
            wrAddr    <= '0;
            wrData    <= '0;
            coreHold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state   <= S_LEN_LO;
                        byteReady <= 1'b1;
                        coreHold  <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        r_chk     <= '0;
                        wrAddr    <= '0;
                        r_idx     <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (w_acc) begin
                        r_len[7:0] <= byteIn;
                        r_state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_acc) begin
                        r_len[15:8] <= byteIn;
                        if (32'(w_len) > CAP) begin
                            r_state   <= S_ERR;
                            byteReady <= 1'b0;
                            error     <= 1'b1;
                        end else if (w_len == 16'd0) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    // The write cycle stalls the stream so a write never meets an accept.
                    if (wrEn) begin
                        wrEn      <= 1'b0;
                        byteReady <= 1'b1;
                        wrAddr    <= wrAddr + PCLEN'(1);
                        r_cnt     <= r_cnt + 16'd1;
                        if (r_cnt + 16'd1 == r_len) begin
                            r_state <= S_CHECK;
                        end
                    end else if (w_acc) begin
                        r_chk <= r_chk ^ byteIn;
                        r_buf <= w_word;
                        if (r_idx == IW'(BPW - 1)) begin
                            r_idx     <= '0;
                            wrData    <= w_word;
                            wrEn      <= 1'b1;
                            byteReady <= 1'b0;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (w_acc) begin
                        byteReady <= 1'b0;
                        if (byteIn == r_chk) begin
                            r_state  <= S_DONE;
                            done     <= 1'b1;
                            coreHold <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            error   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    byteReady <= 1'b0;
                    wrEn      <= 1'b0;
                end
            endcase
        end
    end

endmodule
